seq_detect_param: RTL
=====================

# seq_detect_param

Parametrised serial-pattern detector, the next generation of the team's fixed two-bit-output FSM block. It samples a one-bit serial input `A` under a valid qualifier and compares the most recent `PAT_W` samples against a runtime-loaded pattern. It selects overlapping or non-overlapping detection and reports a one-cycle match pulse, a saturating match count on `Z` and the current state code. It sits between a serial stimulus source and the `ivl_uvm` checker/printf monitors in the FSM test environment.

## Interface
- `PAT_W`, default 4: pattern length in bits, ≥2. First pattern bit is the MSB of `pattern_in`.
- `CNT_W`, default 2: width of match counter `Z`, ≥1.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `load`  in  1  latch `pattern_in`; clear history, fill count and `Z`.
- `pattern_in`  in  PAT_W  pattern to detect; sampled only when `load`=1.
- `overlap`  in  1  1 = overlapping detection, 0 = non-overlapping. Sampled every valid cycle.
- `A`  in  1  serial data bit.
- `A_valid`  in  1  `A` is consumed on a rising edge only when `A_valid`=1.
- `match`  out  1  registered pulse, high for one cycle per detection.
- `Z`  out  CNT_W  registered saturating count of detections since the last reset or load.
- `state`  out  2  registered state code: 00 IDLE, 01 FILL, 10 ARMED. 11 never occurs.

## Operation
- Internal registers:
  - `hist[PAT_W-1:0]`: shift history, newest bit in the LSB.
  - `fill`: number of valid bits held, 0..PAT_W.
  - `pat[PAT_W-1:0]`: the loaded pattern.
- State machine:
  - IDLE: entered on reset. `A`/`A_valid` are ignored. Leaves only on `load` → FILL.
  - FILL: `fill`<PAT_W. Each valid sample shifts `hist` and increments `fill`. Goes to ARMED when `fill` reaches PAT_W.
  - ARMED: `fill`=PAT_W. Each valid sample shifts `hist`. Returns to FILL when a non-overlap match clears `fill`. `load` from any non-IDLE state → FILL.
- Valid sample, when `load`=0 and `A_valid`=1 in FILL/ARMED:
  - `hist_n` = {hist[PAT_W-2:0], A}.
  - `fill_n` = min(fill+1, PAT_W).
  - A detection occurs when `fill_n`=PAT_W and `hist_n`=`pat`.
- On detection:
  - `match` is set to 1 at the same edge.
  - `Z` becomes min(Z+1, 2^CNT_W−1). `Z` holds at all ones and never wraps.
  - If `overlap`=1, `fill` stays PAT_W (ARMED).
  - If `overlap`=0, `fill` is cleared to 0 (FILL).
- `match` is cleared on any edge that has no detection, including cycles with `A_valid`=0. `hist`/`fill`/`Z` hold when `A_valid`=0.
- `load`:
  - `pat`←`pattern_in`; `hist`←0, `fill`←0, `Z`←0, `match`←0, `state`←FILL.
  - `load` has priority over a simultaneous valid sample; that sample is discarded.
- `reset`:
  - Overrides everything, including mid-fill, mid-match and a simultaneous `load`.
  - All registers go to 0: `match`=0, `Z`=0, `state`=IDLE, `pat`=0. A new `load` is required before detection resumes.

## Timing
- Single-cycle latency: the sample consumed at edge k produces `match`/`Z` updates visible after edge k. No combinational path from inputs to outputs.
- The earliest detection after `load` is the PAT_W-th valid sample.
- Non-overlap mode: consecutive detections are at least PAT_W valid samples apart.
- Overlap mode: detections are possible on consecutive valid samples (e.g. pattern all ones).
- `overlap` may change between samples. The mode in force at the detecting edge decides whether `fill` clears.
- Reset values: `match`=0, `Z`=0, `state`=00.

## Test plan
- Reset then `load` 4'b1011 with `overlap`=1. Stream 1,0,1,1,0,1,1 valid every cycle → `match` pulses after the 4th and 7th samples, `Z`=2, `state` 01→10 at the 4th sample.
- Same stream with `overlap`=0 → single `match` after the 4th sample, `Z`=1, `state` returns to 01 and stays there (fill=3 at end).
- `A_valid` gaps: 1,0,1,1 delivered with `A_valid`=0 cycles interleaved → `match` only after the 4th valid sample, `match`=0 on every gap cycle.
- Saturation with CNT_W=2: pattern 4'b1111, `overlap`=1, eight valid 1s → five `match` pulses, `Z` reads 1,2,3,3,3.
- `load` asserted together with a valid sample mid-fill → sample dropped, `Z`=0, `state`=01. The next PAT_W samples equal to the new pattern give the first `match`.
- `reset` asserted in ARMED with `Z`=2 and `load` high the same cycle → `state`=00, `Z`=0, `match`=0. Matching stream afterwards gives no `match` until a new `load`.

Source files
------------

// File: rtl/seq_detect_param.sv
// rtl/seq_detect_param.sv - parametrised serial-pattern detector with saturating match count
//
// Purpose: shifts qualified serial bits into a PAT_W-deep history and compares it against
// a runtime-loaded pattern. It supports overlapping or non-overlapping detection.
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   synchronous active-high reset
//   load        in   latch pattern_in, clear history/fill/count
//   pattern_in  in   [PAT_W-1:0] pattern, first bit in the MSB
//   overlap     in   1 = overlapping detection, 0 = non-overlapping
//   A           in   serial data bit
//   A_valid     in   A is consumed when high
//   match       out  one-cycle detection pulse (registered)
//   Z           out  [CNT_W-1:0] saturating detection count (registered)
//   state       out  [1:0] 00 IDLE, 01 FILL, 10 ARMED (registered)
module seq_detect_param #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap,
    input  logic             A,
    input  logic             A_valid,
    output logic             match,
    output logic [CNT_W-1:0] Z,
    output logic [1:0]       state
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FILL  = 2'b01,
        S_ARMED = 2'b10
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist_q;
    logic [FW-1:0]    fill_q;
    logic [CNT_W-1:0] z_q;
    logic             match_q;

    logic [PAT_W-1:0] hist_d;
    logic [FW-1:0]    fill_d;
    logic             sample;
    logic             detect;

    always_comb begin
        hist_d = {hist_q[PAT_W-2:0], A};
        fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
        // A load on the same edge wins and discards the sample.
        sample = A_valid && !load && (state_q != S_IDLE);
        detect = sample && (fill_d == FULL) && (hist_d == pat_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= '0;
            match_q <= 1'b0;
        end else if (load) begin
            state_q <= S_FILL;
            pat_q   <= pattern_in;
            hist_q  <= '0;
            fill_q  <= '0;
            z_q     <= '0;
            match_q <= 1'b0;
        end else begin
            match_q <= detect;
            if (sample) begin
                hist_q <= hist_d;
                if (detect && (z_q != '1)) begin
                    z_q <= z_q + 1'b1;
                end
                // Non-overlap restarts the fill so the next hit needs PAT_W fresh bits.
                if (detect && !overlap) begin
                    fill_q  <= '0;
                    state_q <= S_FILL;
                end else begin
                    fill_q  <= fill_d;
                    state_q <= (fill_d == FULL) ? S_ARMED : S_FILL;
                end
            end
        end
    end

    assign match = match_q;
    assign Z     = z_q;
    assign state = state_q;

endmodule
